// File: rtl/load_pkg.sv
// Shared load-path definitions: op encodings, widths, output-buffer entry
// layout and buffer occupancy states.
package load_pkg;
   localparam int DATA_W = 32;
   localparam int RD_W   = 5;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;

   typedef struct packed {
      logic              err;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } load_ent_t;

   // Encoded as the entry count so the state doubles as occupancy.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_st_t;
endpackage

// File: rtl/load_lane_ext.sv
// Combinational lane select and sign/zero extension of a raw memory word.
// Shared with the forwarding unit, so it holds no state.
module load_lane_ext
   import load_pkg::*;
(
   input  logic [DATA_W-1:0] in_word,
   input  logic [1:0]        in_addr_lo,
   input  logic [2:0]        in_op,
   output logic [DATA_W-1:0] data,
   output logic              err
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (in_addr_lo)
         2'd0: byte_sel = in_word[7:0];
         2'd1: byte_sel = in_word[15:8];
         2'd2: byte_sel = in_word[23:16];
         2'd3: byte_sel = in_word[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = in_addr_lo[1] ? in_word[31:16] : in_word[15:0];
   end

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (in_op)
         OP_LW:  begin data = in_word;                       err = (in_addr_lo != 2'd0); end
         OP_LH:  begin data = {{16{half_sel[15]}}, half_sel}; err = in_addr_lo[0];        end
         OP_LHU: begin data = {16'h0000, half_sel};          err = in_addr_lo[0];        end
         OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: data = {24'h000000, byte_sel};
         default: err = 1'b1;
      endcase
      // Faulting loads carry zero data so nothing stale leaks into WB.
      if (err) data = '0;
   end
endmodule

// File: rtl/load_data_ext.sv
// MEM/WB load extractor: lane extension feeding a 2-entry in-order output
// queue with a registered in_ready and a synchronous flush.
module load_data_ext #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_word,
   input  logic [1:0]        in_addr_lo,
   input  logic [2:0]        in_op,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_err
);
   import load_pkg::*;

   buf_st_t                st, st_nxt;
   logic                   rd_ptr, wr_ptr;
   load_ent_t [DEPTH-1:0]  ent_q;
   load_ent_t              ent_in;
   logic                   push, pop;

   load_lane_ext u_lane (
      .in_word    (in_word),
      .in_addr_lo (in_addr_lo),
      .in_op      (in_op),
      .data       (ent_in.data),
      .err        (ent_in.err)
   );
   assign ent_in.rd = in_rd;

   assign out_valid = (st != BUF_EMPTY);
   assign out_data  = ent_q[rd_ptr].data;
   assign out_rd    = ent_q[rd_ptr].rd;
   assign out_err   = ent_q[rd_ptr].err;

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_comb begin
      st_nxt = st;
      if (flush) st_nxt = BUF_EMPTY;
      else begin
         case (st)
            BUF_EMPTY: if (push) st_nxt = BUF_ONE;
            BUF_ONE: begin
               if (push && !pop)      st_nxt = BUF_FULL;
               else if (pop && !push) st_nxt = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) st_nxt = BUF_ONE;
            default:   st_nxt = BUF_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= BUF_EMPTY;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         in_ready <= 1'b0;
         ent_q    <= '0;
      end else begin
         st       <= st_nxt;
         // Registered off next occupancy so WB backpressure never reaches in_ready combinationally.
         in_ready <= (st_nxt != BUF_FULL);
         if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            if (push) begin
               ent_q[wr_ptr] <= ent_in;
               wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
         end
      end
   end
endmodule

// File: doc/load_data_ext.md
Name: load_data_ext

Overview:
- MEM/WB-side load-data extractor for the pipelined CPU.
- Takes the raw 32-bit word from data memory, selects the addressed byte or halfword lane, and sign- or zero-extends it to 32 bits. It is the read-side counterpart of the immediate/store-side packers.
- Result is buffered in a 2-entry output queue with valid/ready handshake, so WB stalls never drop a load.
- Misaligned accesses and illegal opcodes are flagged, not trapped, here.

Parameters:
- DATA_W, 32: datapath width; only 32 is supported.
- RD_W, 5: destination register index width.
- DEPTH, 2: output buffer entries; only 2 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  load request present.
- in_ready  out  1  block can accept a request this cycle (registered).
- in_word  in  32  raw memory word, little-endian lanes.
- in_addr_lo  in  2  byte address bits [1:0].
- in_op  in  3  load type (package constants).
- in_rd  in  5  destination register tag, passed through.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  head entry valid.
- out_ready  in  1  WB accepts the head entry.
- out_data  out  32  extended load result.
- out_rd  out  5  tag of the head entry.
- out_err  out  1  misaligned access or illegal op for the head entry.

Behaviour:
- Reset is asynchronous: count=0, rd_ptr=wr_ptr=0, in_ready=0, out_valid=0, out_data=0, out_rd=0, out_err=0, all entries cleared.
- in_ready rises on the first rising edge with rst_n high.
- Op codes:
  - 000 LW: whole word. Error if addr_lo != 0.
  - 001 LH: sign-extend halfword word[16*addr_lo[1] +: 16]. Error if addr_lo[0] = 1.
  - 010 LHU: zero-extend the same halfword. Same error rule as LH.
  - 011 LB: sign-extend byte word[8*addr_lo +: 8].
  - 100 LBU: zero-extend the same byte.
  - 101..111: illegal, error.
- On error the stored data is 0x00000000 and err=1. The entry is still enqueued so WB can raise the exception in order.
- Push occurs when in_valid & in_ready & !flush. The entry written is {data, rd, err}.
- Pop occurs when out_valid & out_ready.
- Latency: a request accepted at edge N while empty gives out_valid=1 with its result after edge N, i.e. one cycle later.
- Buffer states:
  - EMPTY (count 0): push -> ONE.
  - ONE (count 1): push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, new entry becomes head next cycle.
  - FULL (count 2): pop -> ONE. No push is possible because in_ready=0.
- Pointers are 1 bit and wrap modulo 2. Output order equals acceptance order.
- in_ready is registered to (count_next < 2). It never depends combinationally on out_ready.
- out_valid = (count != 0). out_data, out_rd and out_err come from the head entry and stay stable while out_valid & !out_ready.
- flush:
  - Next state is count=0 and both pointers 0.
  - Any push requested in the same cycle is discarded.
  - out_valid=0 and in_ready=1 after the edge.
  - flush overrides a pop in the same cycle.
- Reset mid-operation: all buffered entries are lost immediately, no partial output.

Decomposition:
- Shared package load_pkg holds:
  - op constants OP_LW=3'b000, OP_LH=3'b001, OP_LHU=3'b010, OP_LB=3'b011, OP_LBU=3'b100;
  - DATA_W and RD_W;
  - the entry record layout {err, rd, data}.
- One combinational sub-module, load_lane_ext: inputs in_word, in_addr_lo, in_op; outputs data and err. It is reusable by the forwarding unit.
- The buffer and handshake logic stays in load_data_ext.

Test Plan:
- Byte lanes, in_word=0x8765A3C4, out_ready=1:
  - LB addr0 -> 0xFFFFFFC4.
  - LBU addr0 -> 0x000000C4.
  - LB addr2 -> 0x00000065.
  - LB addr3 -> 0xFFFFFF87.
  - Each arrives one cycle after acceptance with err=0 and rd passed through.
- Halfword lanes, same word:
  - LH addr0 -> 0xFFFFA3C4.
  - LHU addr2 -> 0x00008765.
  - LH addr2 -> 0xFFFF8765.
  - LH addr1 -> data 0x00000000, err=1.
  - LW addr0 -> 0x8765A3C4.
  - LW addr3 -> err=1.
  - in_op=3'b110 -> err=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back requests (rd 1, 2, 3).
  - Only rd 1 and 2 are accepted; in_ready=0 from the cycle after the second accept.
  - Raise out_ready: outputs appear in order 1, 2, 3, and in_ready returns to 1 after the first pop.
- Simultaneous push and pop in ONE: count stays 1 and the new result appears at the head on the next cycle.
- Flush while FULL, with in_valid=1 the same cycle: next cycle out_valid=0, in_ready=1, and the flushed-cycle request never appears.
- Reset mid-stream: pull rst_n low asynchronously with 2 entries held.
  - All outputs drop to 0 immediately and in_ready=0.
  - in_ready=1 on the first edge after release.
  - No stale entry is emitted afterwards.
